// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C/SCCB write master: FSM encoding and quarter indices.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Each SCL bit period is split into four equal quarters.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-bit divider: one-cycle tick every QTR clocks while enabled, held at zero otherwise.
module i2c_qtr_tick #(
  parameter int QTR = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(QTR);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(QTR - 1));

  // Count 0..QTR-1; restart from zero whenever disabled so each transaction starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_n.sv
// Multi-byte I2C/SCCB write master: START, 1..MAX_BYTES bytes MSB-first with ACK slot, STOP.
module i2c_master_n
  import i2c_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int SCL_HZ    = 100_000,
  parameter int MAX_BYTES = 3,
  parameter int ACK_CHECK = 1
) (
  input  logic                           meg25,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_BYTES+1)-1:0] num_bytes,
  input  logic [8*MAX_BYTES-1:0]         wr_dat,
  output logic                           scl,
  inout  wire                            sda,
  output logic                           busy,
  output logic                           done,
  output logic                           nack,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count
);

  localparam int QTR = CLK_HZ / (4 * SCL_HZ);
  localparam int NBW = $clog2(MAX_BYTES + 1);
  localparam int DW  = 8 * MAX_BYTES;

  state_t         state_q, state_n;
  logic [1:0]     qtr_q, qtr_n;
  logic [2:0]     bit_q, bit_n;
  logic [NBW-1:0] left_q, left_n;
  logic [NBW-1:0] count_q, count_n;
  logic [DW-1:0]  shreg_q, shreg_n;
  logic           ack_q, ack_n;
  logic           abort_q, abort_n;
  logic           done_q, done_n;
  logic           nack_q, nack_n;
  logic           scl_q, scl_n;
  logic           sda_low_q, sda_low_n;
  logic           tick;
  logic           sda_in;

  assign sda        = sda_low_q ? 1'b0 : 1'bz;
  assign sda_in     = sda;
  assign scl        = scl_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign nack       = nack_q;
  assign byte_count = count_q;

  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .clk   (meg25),
    .rst_n (rst_n),
    .en    (busy),
    .tick  (tick)
  );

  // State and pin registers; pins are registered from next-state so they never glitch.
  always_ff @(posedge meg25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      qtr_q     <= Q0;
      bit_q     <= 3'd7;
      left_q    <= '0;
      count_q   <= '0;
      shreg_q   <= '0;
      ack_q     <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      qtr_q     <= qtr_n;
      bit_q     <= bit_n;
      left_q    <= left_n;
      count_q   <= count_n;
      shreg_q   <= shreg_n;
      ack_q     <= ack_n;
      abort_q   <= abort_n;
      done_q    <= done_n;
      nack_q    <= nack_n;
      scl_q     <= scl_n;
      sda_low_q <= sda_low_n;
    end
  end

  // Next-state sequencing on quarter ticks, then pin levels decoded from the next state.
  always_comb begin
    state_n   = state_q;
    qtr_n     = qtr_q;
    bit_n     = bit_q;
    left_n    = left_q;
    count_n   = count_q;
    shreg_n   = shreg_q;
    ack_n     = ack_q;
    abort_n   = abort_q;
    done_n    = 1'b0;
    nack_n    = nack_q;
    scl_n     = 1'b1;
    sda_low_n = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (num_bytes != '0)) begin
          state_n = START;
          qtr_n   = Q0;
          shreg_n = wr_dat;
          left_n  = (num_bytes > NBW'(MAX_BYTES)) ? NBW'(MAX_BYTES) : num_bytes;
          count_n = '0;
          nack_n  = 1'b0;
          abort_n = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (qtr_q == Q1) begin
            state_n = BIT;
            qtr_n   = Q0;
            bit_n   = 3'd7;
          end else begin
            qtr_n = qtr_q + 2'd1;
          end
        end
      end
      BIT: begin
        if (tick) begin
          if (qtr_q == Q3) begin
            // Shift on the bit boundary; after eight shifts the next byte sits at the MSB.
            shreg_n = {shreg_q[DW-2:0], 1'b0};
            qtr_n   = Q0;
            if (bit_q == 3'd0) begin
              state_n = ACK;
            end else begin
              bit_n = bit_q - 3'd1;
            end
          end else begin
            qtr_n = qtr_q + 2'd1;
          end
        end
      end
      ACK: begin
        if (tick) begin
          // Sampling as Q2 begins puts the read in the middle of the SCL high time.
          if (qtr_q == Q1) begin
            ack_n = sda_in;
          end
          if (qtr_q == Q3) begin
            qtr_n = Q0;
            if (ack_q && (ACK_CHECK != 0)) begin
              abort_n = 1'b1;
              state_n = STOP;
            end else begin
              if (count_q != NBW'(MAX_BYTES)) begin
                count_n = count_q + NBW'(1);
              end
              if (left_q > NBW'(1)) begin
                left_n  = left_q - NBW'(1);
                bit_n   = 3'd7;
                state_n = BIT;
              end else begin
                state_n = STOP;
              end
            end
          end else begin
            qtr_n = qtr_q + 2'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (qtr_q == Q3) begin
            state_n = IDLE;
            qtr_n   = Q0;
            done_n  = 1'b1;
            nack_n  = abort_q;
          end else begin
            qtr_n = qtr_q + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START: begin
        sda_low_n = 1'b1;
      end
      BIT: begin
        scl_n     = (qtr_n == Q1) || (qtr_n == Q2);
        sda_low_n = ~shreg_n[DW-1];
      end
      ACK: begin
        scl_n = (qtr_n == Q1) || (qtr_n == Q2);
      end
      STOP: begin
        scl_n     = (qtr_n != Q0);
        sda_low_n = (qtr_n == Q0) || (qtr_n == Q1);
      end
      default: begin
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_n.sv
// Scoreboard bench for i2c_master_n: bus decoder + ACK slave, expected transactions queued by stimulus.
module tb_i2c_master_n;

  typedef struct {
    logic [23:0] bytes;
    int          nb;
    int          bc;
    int          nk;
    int          acc;
    int          lat;
  } exp_t;

  logic        meg25;
  logic        rst_n;
  logic        start;
  logic [1:0]  num_bytes;
  logic [23:0] wr_dat;
  logic        scl;
  wire         sda;
  logic        busy;
  logic        done;
  logic        nack;
  logic [1:0]  byte_count;

  logic        slave_low;
  int          vec;
  int          miss;
  int          cyc;
  int          nack_idx;
  exp_t        exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  sh;
  logic        prev_scl;
  logic        prev_sda;
  logic        in_txn;
  int          bitcnt;
  int          nbyte;
  int          start_seen;
  int          stop_seen;
  int          scl_edges;
  int          done_cnt;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_master_n #(
    .CLK_HZ    (4_000_000),
    .SCL_HZ    (100_000),
    .MAX_BYTES (3),
    .ACK_CHECK (1)
  ) dut (
    .meg25      (meg25),
    .rst_n      (rst_n),
    .start      (start),
    .num_bytes  (num_bytes),
    .wr_dat     (wr_dat),
    .scl        (scl),
    .sda        (sda),
    .busy       (busy),
    .done       (done),
    .nack       (nack),
    .byte_count (byte_count)
  );

  initial meg25 = 1'b0;
  always #5 meg25 = ~meg25;

  initial cyc = 0;
  always @(posedge meg25) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    vec++;
    if (act != req) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bus decoder, ACK-driving slave and scoreboard, all sampled on the falling clock edge.
  always @(negedge meg25) begin
    exp_t e;
    if (!rst_n) begin
      in_txn = 1'b0; bitcnt = 0; nbyte = 0; slave_low = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1;
      got_q.delete(); start_seen = 0; stop_seen = 0;
    end else begin
      if (scl != prev_scl) scl_edges++;
      if (scl && prev_scl && prev_sda && !sda) begin
        start_seen++; in_txn = 1'b1; bitcnt = 0; nbyte = 0;
      end else if (scl && prev_scl && !prev_sda && sda) begin
        stop_seen++; in_txn = 1'b0;
      end else if (in_txn && scl && !prev_scl) begin
        if (bitcnt < 8) sh = {sh[6:0], sda};
        bitcnt++;
        if (bitcnt == 8) got_q.push_back(sh);
      end else if (in_txn && !scl && prev_scl) begin
        if (bitcnt == 8) begin
          slave_low = (nbyte != nack_idx);
        end else if (bitcnt == 9) begin
          slave_low = 1'b0; bitcnt = 0; nbyte++;
        end
      end
      prev_scl = scl;
      prev_sda = sda;

      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc - e.acc, e.lat);
          chk("byte_count", int'(byte_count), e.bc);
          chk("nack", int'(nack), e.nk);
          chk("busy_at_done", int'(busy), 0);
          chk("start_cond", start_seen, 1);
          chk("stop_cond", stop_seen, 1);
          chk("bytes_on_bus", got_q.size(), e.nb);
          for (int i = 0; i < e.nb && i < got_q.size(); i++)
            chk($sformatf("byte%0d", i), int'(got_q[i]), int'(e.bytes[23-8*i -: 8]));
          got_q.delete();
          start_seen = 0;
          stop_seen  = 0;
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge meg25);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic send(input int n, input logic [23:0] d, input int nk_at,
                      input int enb, input int ebc, input int enk, input int lat,
                      input bit scramble);
    exp_t e;
    @(negedge meg25);
    nack_idx  = nk_at;
    num_bytes = 2'(n);
    wr_dat    = d;
    start     = 1'b1;
    e = '{bytes: d, nb: enb, bc: ebc, nk: enk, acc: cyc + 1, lat: lat};
    exp_q.push_back(e);
    @(negedge meg25);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    chk("nack_cleared", int'(nack), 0);
    chk("byte_count_cleared", int'(byte_count), 0);
    if (scramble) begin
      wr_dat    = ~d;
      num_bytes = 2'd1;
    end
    wait_drain(3000);
  endtask

  initial begin
    exp_t e;
    int   base_edges;
    int   base_done;
    int   n;
    vec = 0; miss = 0; nack_idx = -1;
    scl_edges = 0; done_cnt = 0;
    start = 1'b0; num_bytes = 2'd0; wr_dat = 24'h0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge meg25);
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda", int'(sda), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_nack", int'(nack), 0);
    chk("rst_byte_count", int'(byte_count), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge meg25);

    // Three bytes, all ACKed; inputs scrambled while busy
    send(3, 24'h42_12_80, -1, 3, 3, 0, 1140, 1'b1);

    // NACK on second byte aborts to STOP
    base_done = done_cnt;
    send(3, 24'hA5_3C_0F, 1, 2, 1, 1, 780, 1'b0);
    repeat (50) @(negedge meg25);
    chk("single_done_on_abort", done_cnt - base_done, 1);
    chk("nack_held", int'(nack), 1);

    // Single byte of all ones
    send(1, 24'hFF_00_00, -1, 1, 1, 0, 420, 1'b0);

    // Zero byte count is ignored
    base_edges = scl_edges;
    base_done  = done_cnt;
    @(negedge meg25);
    num_bytes = 2'd0; wr_dat = 24'h55_55_55; start = 1'b1;
    @(negedge meg25);
    start = 1'b0;
    repeat (2000) @(negedge meg25);
    chk("zero_len_scl_edges", scl_edges - base_edges, 0);
    chk("zero_len_done", done_cnt - base_done, 0);
    chk("zero_len_busy", int'(busy), 0);

    // start held high through busy and the done cycle: two back-to-back transactions
    @(negedge meg25);
    nack_idx = -1; num_bytes = 2'd2; wr_dat = 24'h5A_C3_00; start = 1'b1;
    e = '{bytes: 24'h5A_C3_00, nb: 2, bc: 2, nk: 0, acc: cyc + 1, lat: 780};
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge meg25);
      n++;
    end while (!done && n < 3000);
    if (!done) begin
      chk("held_start_done_timeout", 0, 1);
    end else begin
      e = '{bytes: 24'h5A_C3_00, nb: 2, bc: 2, nk: 0, acc: cyc + 1, lat: 780};
      exp_q.push_back(e);
    end
    @(negedge meg25);
    start = 1'b0;
    chk("second_txn_started", int'(busy), 1);
    wait_drain(3000);

    // Reset while bit 4 of the first byte is on the bus
    base_done = done_cnt;
    @(negedge meg25);
    nack_idx = -1; num_bytes = 2'd3; wr_dat = 24'h42_12_80; start = 1'b1;
    @(negedge meg25);
    start = 1'b0;
    n = 0;
    while (!(in_txn && nbyte == 0 && bitcnt == 3) && n < 2000) begin
      @(negedge meg25);
      n++;
    end
    chk("reached_bit4", int'(in_txn && nbyte == 0 && bitcnt == 3), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_scl", int'(scl), 1);
    chk("midrst_sda", int'(sda), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    repeat (5) @(negedge meg25);
    rst_n = 1'b1;
    repeat (200) @(negedge meg25);
    chk("midrst_no_done", done_cnt - base_done, 0);
    chk("midrst_idle_scl", int'(scl), 1);

    // Clean transaction after the reset
    send(3, 24'h42_12_80, -1, 3, 3, 0, 1140, 1'b0);

    repeat (20) @(negedge meg25);
    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
